// File: rtl/iq_decim_pkg.sv
// Shared constants, FIFO word layout and log2 helper for the IQ decimator.
//   SAMPLE_W : width of one signed input sample
//   LANES    : samples per input beat
//   OUT_W    : width of one rounded output component
//   ACC_W    : group accumulator width (holds 32 * -8192 exactly)
package iq_decim_pkg;

    localparam int unsigned SAMPLE_W = 14;
    localparam int unsigned LANES    = 4;
    localparam int unsigned OUT_W    = 16;
    localparam int unsigned ACC_W    = 19;
    localparam int unsigned IN_W     = SAMPLE_W * LANES;
    localparam int unsigned WORD_W   = 2 * OUT_W;
    localparam int unsigned FIFO_W   = WORD_W + 1;

    // One FIFO entry: frame-last flag stored alongside the {Q, I} word.
    typedef struct packed {
        logic                    last;
        logic signed [OUT_W-1:0] q;
        logic signed [OUT_W-1:0] i;
    } fifo_word_t;

    // Ceiling log2; exact for powers of two.
    function automatic int unsigned log2_ceil(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((r < 32) && ((33'd1 << r) < 33'(n))) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/iq_decimator_if.sv
// Stream bundle of the IQ decimator: 4-lane I/Q input beats (no backpressure)
// and the AXI-stream style output with its overflow counter.
//   slave  : view of the decimator itself
//   master : view of the environment driving beats and consuming words
interface iq_decimator_if;
    import iq_decim_pkg::*;

    logic              in_valid_i;
    logic [IN_W-1:0]   inphase_i;
    logic [IN_W-1:0]   quadrature_i;
    logic              m_tvalid_o;
    logic              m_tready_i;
    logic [WORD_W-1:0] m_tdata_o;
    logic              m_tlast_o;
    logic [15:0]       overflow_cnt_o;

    modport slave (
        input  in_valid_i,
        input  inphase_i,
        input  quadrature_i,
        input  m_tready_i,
        output m_tvalid_o,
        output m_tdata_o,
        output m_tlast_o,
        output overflow_cnt_o
    );

    modport master (
        output in_valid_i,
        output inphase_i,
        output quadrature_i,
        output m_tready_i,
        input  m_tvalid_o,
        input  m_tdata_o,
        input  m_tlast_o,
        input  overflow_cnt_o
    );

endinterface

// File: rtl/iq_fifo.sv
// Single-clock show-ahead FIFO with a registered head word.
//   clk_i, rst_i : clock, synchronous active-low reset
//   wr_en_i      : push request; ignored when full unless a pop happens too
//   wr_data_i    : word to push
//   rd_en_i      : pop request; only honoured while rd_valid_o is high
//   rd_valid_o   : head word present (registered)
//   rd_data_o    : head word (registered, held until popped)
//   full_o       : occupancy equals DEPTH (registered)
module iq_fifo
    import iq_decim_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_W,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic             rd_valid_o,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o
);

    localparam int unsigned AW = log2_ceil(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    rd_nxt;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic             push, pop;

    // Pointer/occupancy update and head prefetch.
    always_comb begin
        pop      = rd_en_i && valid_q;
        push     = wr_en_i && (!full_q || pop);
        rd_nxt   = rd_ptr_q + AW'(1);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_nxt : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        head_d   = head_q;
        if (pop) begin
            // With one word left the next head can only be the word arriving now.
            if (count_q == CW'(1)) begin
                if (push) begin
                    head_d = wr_data_i;
                end
            end else begin
                head_d = mem_q[rd_nxt];
            end
        end else if ((count_q == '0) && push) begin
            // Empty: the word appears one cycle after the push, never bypassed.
            head_d = wr_data_i;
        end
        valid_d = (count_d != '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    // Control state.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    // Storage array; contents are only meaningful behind the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q;
    assign rd_data_o  = head_q;
    assign full_o     = full_q;

endmodule

// File: rtl/iq_decimator.sv
// Integrate-and-dump IQ decimator: sums DECIM consecutive I and Q samples
// (DECIM/4 valid beats of 4 lanes), rounds by 2^(log2(DECIM)-2) and queues
// {Q, I} words in an output FIFO with drop counting on overflow.
// Optional framing: define IQ_DECIM_FRAME_EN to tag every FRAME_LEN-th
// accepted word with m_tlast_o; otherwise m_tlast_o is tied low.
//   clk_i : processing clock
//   rst_i : synchronous active-low reset
//   bus   : iq_decimator_if.slave (input beats, output stream, overflow count)
module iq_decimator
    import iq_decim_pkg::*;
#(
    parameter int unsigned DECIM      = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FRAME_LEN  = 256
) (
    input  logic           clk_i,
    input  logic           rst_i,
    iq_decimator_if.slave  bus
);

    localparam int unsigned BEATS    = DECIM / LANES;
    localparam int unsigned BCNT_W   = (BEATS > 1) ? log2_ceil(BEATS) : 1;
    localparam int unsigned SHIFT    = log2_ceil(DECIM) - 2;
    localparam int unsigned RND_HALF = (SHIFT == 0) ? 0 : (32'd1 << (SHIFT - 1));

    logic signed [ACC_W-1:0] lane_sum_i, lane_sum_q;
    logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
    logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic                    grp_done_q, grp_done_d;
    logic                    last_beat;

    logic signed [ACC_W-1:0] sum_i, sum_q, shf_i, shf_q;
    logic signed [OUT_W-1:0] res_i_q, res_i_d, res_q_q, res_q_d;
    logic                    res_vld_q;

    fifo_word_t              wr_word, rd_word;
    logic                    fifo_valid, fifo_full;
    logic                    pop, accept, drop;
    logic                    last_tag;
    logic [15:0]             ovf_q, ovf_d;

    // Per-beat sum of the four sign-extended lanes.
    always_comb begin
        lane_sum_i = '0;
        lane_sum_q = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum_i = lane_sum_i + ACC_W'($signed(bus.inphase_i[k*SAMPLE_W +: SAMPLE_W]));
            lane_sum_q = lane_sum_q + ACC_W'($signed(bus.quadrature_i[k*SAMPLE_W +: SAMPLE_W]));
        end
    end

    // Group accumulation: first beat loads, later beats add, idle beats hold.
    always_comb begin
        bcnt_d     = bcnt_q;
        acc_i_d    = acc_i_q;
        acc_q_d    = acc_q_q;
        grp_done_d = 1'b0;
        last_beat  = (bcnt_q == BCNT_W'(BEATS - 1));
        if (bus.in_valid_i) begin
            acc_i_d    = (bcnt_q == '0) ? lane_sum_i : acc_i_q + lane_sum_i;
            acc_q_d    = (bcnt_q == '0) ? lane_sum_q : acc_q_q + lane_sum_q;
            bcnt_d     = last_beat ? '0 : bcnt_q + BCNT_W'(1);
            grp_done_d = last_beat;
        end
    end

    // Round half up and arithmetic shift; the result always fits OUT_W.
    always_comb begin
        sum_i   = acc_i_q + $signed(ACC_W'(RND_HALF));
        sum_q   = acc_q_q + $signed(ACC_W'(RND_HALF));
        shf_i   = sum_i >>> SHIFT;
        shf_q   = sum_q >>> SHIFT;
        res_i_d = shf_i[OUT_W-1:0];
        res_q_d = shf_q[OUT_W-1:0];
    end

    // A push is accepted if there is room or the head leaves in the same cycle.
    always_comb begin
        pop    = fifo_valid && bus.m_tready_i;
        accept = res_vld_q && (!fifo_full || pop);
        drop   = res_vld_q && fifo_full && !pop;
        ovf_d  = (drop && (ovf_q != 16'hFFFF)) ? ovf_q + 16'd1 : ovf_q;
    end

    // Accumulator, rounding stage and overflow counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            bcnt_q     <= '0;
            acc_i_q    <= '0;
            acc_q_q    <= '0;
            grp_done_q <= 1'b0;
            res_i_q    <= '0;
            res_q_q    <= '0;
            res_vld_q  <= 1'b0;
            ovf_q      <= '0;
        end else begin
            bcnt_q     <= bcnt_d;
            acc_i_q    <= acc_i_d;
            acc_q_q    <= acc_q_d;
            grp_done_q <= grp_done_d;
            res_i_q    <= res_i_d;
            res_q_q    <= res_q_d;
            res_vld_q  <= grp_done_q;
            ovf_q      <= ovf_d;
        end
    end

`ifdef IQ_DECIM_FRAME_EN
    localparam int unsigned FRM_W = (FRAME_LEN > 1) ? log2_ceil(FRAME_LEN) : 1;

    logic [FRM_W-1:0] frm_q, frm_d;

    // Frame position of accepted words; dropped words are not counted.
    always_comb begin
        last_tag = (frm_q == FRM_W'(FRAME_LEN - 1));
        frm_d    = frm_q;
        if (accept) begin
            frm_d = last_tag ? '0 : frm_q + FRM_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            frm_q <= '0;
        end else begin
            frm_q <= frm_d;
        end
    end

    assign bus.m_tlast_o = rd_word.last;
`else
    logic unused_last;

    assign last_tag      = 1'b0;
    assign unused_last   = rd_word.last;
    assign bus.m_tlast_o = 1'b0;
`endif

    assign wr_word.last = last_tag;
    assign wr_word.q    = res_q_q;
    assign wr_word.i    = res_i_q;

    iq_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    (res_vld_q),
        .wr_data_i  (wr_word),
        .rd_en_i    (bus.m_tready_i),
        .rd_valid_o (fifo_valid),
        .rd_data_o  (rd_word),
        .full_o     (fifo_full)
    );

    assign bus.m_tvalid_o     = fifo_valid;
    assign bus.m_tdata_o      = {rd_word.q, rd_word.i};
    assign bus.overflow_cnt_o = ovf_q;

endmodule

// File: doc/iq_decimator.md
IQ_DECIMATOR -- requirements
Module: iq_decimator

Interface
REQ-001 The block SHALL have one clock, clk_i; reset rst_i SHALL be synchronous and active-low.
REQ-002 Parameter DECIM, default 16, SHALL set the decimation factor; legal values are 4, 8, 16 and 32.
REQ-003 Parameter FIFO_DEPTH, default 16, SHALL set the output FIFO depth in words; it must be a power of 2 and at least 4.
REQ-004 Parameter FRAME_LEN, default 256, SHALL set the number of output words per frame; it must be at least 1.
REQ-005 Port clk_i, input, 1 bit: 250 MHz processing clock.
REQ-006 Port rst_i, input, 1 bit: synchronous active-low reset.
REQ-007 Port in_valid_i, input, 1 bit: the input beat is valid; the input has no backpressure.
REQ-008 Port inphase_i, input, 56 bits: four signed 14-bit filtered I samples; lane k is bits [14k+13:14k], and lane 0 is the oldest.
REQ-009 Port quadrature_i, input, 56 bits: four signed 14-bit Q samples, same lane layout as inphase_i.
REQ-010 Port m_tvalid_o, output, 1 bit: an output word is available.
REQ-011 Port m_tready_i, input, 1 bit: downstream accepts the word.
REQ-012 Port m_tdata_o, output, 32 bits: {Q[15:0], I[15:0]}, signed.
REQ-013 Port m_tlast_o, output, 1 bit: marks the last word of a frame.
REQ-014 Port overflow_cnt_o, output, 16 bits: number of dropped words, saturating.

Function
REQ-015 The block SHALL form a group from D/4 consecutive valid beats, i.e. D samples, using a beat counter that wraps at D/4-1; beats with in_valid_i low SHALL NOT advance the counter or the accumulators.
REQ-016 Per group, separately for I and Q, the block SHALL compute S as the signed sum of all D samples in a 19-bit accumulator; the first beat of a group SHALL load the accumulator and later beats SHALL add to it.
REQ-017 The output value SHALL be (S + 2^(s-1)) >>> s, with s = log2(D) - 2, taken as 16 bits; this result always fits in 16 bits, so no saturation is needed.
REQ-018 Pipeline timing: the last beat of a group is sampled at edge t; the sum is registered at t+1; the rounded word is pushed into the FIFO at t+2; when the FIFO was empty, m_tvalid_o SHALL be high from cycle t+3.
REQ-019 The FIFO SHALL be show-ahead; a word transfers when m_tvalid_o and m_tready_i are both high.
REQ-020 Once asserted, m_tvalid_o and m_tdata_o SHALL hold stable until the transfer completes.
REQ-021 Words SHALL leave the block in the order they were produced.
REQ-022 A push into a full FIFO with no pop in the same cycle SHALL drop the new word and increment overflow_cnt_o; the counter saturates at 0xFFFF.
REQ-023 A push and a pop in the same cycle on a full FIFO SHALL both succeed, leaving the occupancy unchanged.
REQ-024 A push and a pop in the same cycle on an empty FIFO SHALL NOT bypass the FIFO; the word is presented at the following cycle.

Reset
REQ-025 While rst_i is low the block SHALL clear the beat counter, the accumulators, the pipeline valid bits, the FIFO pointers, the frame counter and overflow_cnt_o.
REQ-026 During reset the outputs SHALL be: m_tvalid_o=0, m_tdata_o=0, m_tlast_o=0.
REQ-027 A reset asserted mid-group or mid-frame SHALL discard the partial group and any buffered words; the first group after reset SHALL start at the first valid beat.

Configuration
REQ-028 With IQ_DECIM_FRAME_EN defined, the block SHALL count transferred words and drive m_tlast_o high on the word with index FRAME_LEN-1, then restart the count at 0; m_tlast_o SHALL be stored in the FIFO alongside its word, and dropped words do not count.
REQ-029 Without IQ_DECIM_FRAME_EN, m_tlast_o SHALL be tied to 0 and no frame counter SHALL exist.

Structure
REQ-030 Package iq_decim_pkg SHALL hold the shared constants SAMPLE_W=14, LANES=4, OUT_W=16 and ACC_W=19, plus the log2 helper function.
REQ-031 The FIFO SHALL be a separate sub-module, iq_fifo, with single-clock, show-ahead storage; its data width is parameterised and equals 33 bits (32 data bits plus the last flag).

Verification
REQ-032 With DECIM=16, all lanes I=+100 and Q=-100, and continuous valid: the first word is 0xFE70_0190, with m_tvalid_o high 3 cycles after the 4th beat, and one word every 4 beats thereafter.
REQ-033 Rounding with DECIM=8: lanes summing to S=+3 produce I=2; lanes summing to S=-3 produce I=-1; lanes summing to S=-5 produce I=-2.
REQ-034 Full-scale with DECIM=32: all samples -8192 produce I=0x8000; all samples +8191 produce I=0x7FFC.
REQ-035 Backpressure with FIFO_DEPTH=16: hold m_tready_i=0 for 20 groups, giving overflow_cnt_o=4; on release, exactly 16 words drain in order with no gaps.
REQ-036 Reset: pull rst_i low for 1 cycle after 2 of 4 beats; no word is produced from that partial group, and the next word reflects 4 fresh beats.
REQ-037 Framing: with FRAME_LEN=4 and the macro defined, m_tlast_o is high on words 3, 7 and 11 under random m_tready_i; with the macro undefined, m_tlast_o stays 0.
